ibex_data_mem_arbiter: RTL

- Two-requester arbiter sharing the single Ibex data memory port (req/gnt/rvalid protocol) between requester 0 (core LSU) and requester 1 (debug/DMA master).
- Round-robin grant with request locking.
- A per-transaction owner FIFO routes each rvalid/rdata/err back to the requester that issued it.
- Sits between the requesters and the data memory agent/model.

---
 rtl/ibex_data_mem_arbiter_if.sv | 39 +++
 rtl/ibex_data_mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the requesters plus the memory agent.
interface ibex_data_mem_arbiter_if;
  // requester side
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [7:0]  be_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  // memory side
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );
endinterface

// File: rtl/ibex_data_mem_arbiter.sv
// Two-requester round-robin arbiter for the Ibex data memory port.
// Once a request has been presented without a grant, it stays locked to its
// requester until the grant arrives. A small owner FIFO records who issued
// each granted transaction. The in-order responses are then steered back
// using the owner at the FIFO head.
module ibex_data_mem_arbiter #(
  parameter  int NUM_OUT = 2,
  localparam int CNT_W   = $clog2(NUM_OUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  ibex_data_mem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]          outstanding_o,
  output logic                      protocol_err_o
);

  localparam int PTR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_OUT);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_own;
  logic             w_own_nxt;
  logic             r_prio;
  logic             r_fifo [NUM_OUT];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_perr;

  logic w_active;
  logic w_sel;
  logic w_drop;
  logic w_push;
  logic w_pop;
  logic w_spurious;
  logic w_empty;
  logic w_full;
  logic w_head;

  // Circular pointer advance that wraps at the last FIFO slot.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_head     = r_fifo[r_rptr];
  assign w_push     = w_active & bus.data_gnt_i;
  assign w_pop      = bus.data_rvalid_i & ~w_empty;
  assign w_spurious = bus.data_rvalid_i & w_empty;

  // Next-state logic: picks the active requester, and handles entering and leaving the lock.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_active    = 1'b0;
    w_sel       = r_prio;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|bus.req_i) && !w_full) begin
          w_active = 1'b1;
          w_sel    = bus.req_i[r_prio] ? r_prio : ~r_prio;
          if (bus.data_gnt_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOCKED;
            w_own_nxt   = w_sel;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        w_sel = r_own;
        if (bus.req_i[r_own]) begin
          w_active = 1'b1;
          if (bus.data_gnt_i) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end else begin
          // The requester withdrew while holding the lock: treat it as a violation and drop it.
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output muxing. Everything is held at zero while reset is asserted.
  always_comb begin
    bus.gnt_o         = 2'b00;
    bus.rvalid_o      = 2'b00;
    bus.rdata_o       = 32'h0000_0000;
    bus.err_o         = 1'b0;
    bus.data_req_o    = 1'b0;
    bus.data_we_o     = 1'b0;
    bus.data_be_o     = 4'h0;
    bus.data_addr_o   = 32'h0000_0000;
    bus.data_wdata_o  = 32'h0000_0000;
    outstanding_o     = '0;
    protocol_err_o    = 1'b0;
    if (!rst_ni) begin
      bus.data_req_o  = 1'b0;
    end else begin
      outstanding_o   = r_count;
      protocol_err_o  = r_perr;
      bus.data_req_o  = w_active;
      if (w_active) begin
        bus.data_we_o    = w_sel ? bus.we_i[1]          : bus.we_i[0];
        bus.data_be_o    = w_sel ? bus.be_i[7:4]        : bus.be_i[3:0];
        bus.data_addr_o  = w_sel ? bus.addr_i[63:32]    : bus.addr_i[31:0];
        bus.data_wdata_o = w_sel ? bus.wdata_i[63:32]   : bus.wdata_i[31:0];
        bus.gnt_o        = w_sel ? {bus.data_gnt_i, 1'b0} : {1'b0, bus.data_gnt_i};
      end else begin
        bus.gnt_o        = 2'b00;
      end
      if (w_pop) begin
        bus.rvalid_o = w_head ? 2'b10 : 2'b01;
      end else begin
        bus.rvalid_o = 2'b00;
      end
      if (bus.data_rvalid_i) begin
        bus.rdata_o = bus.data_rdata_i;
        bus.err_o   = bus.data_err_i;
      end else begin
        bus.rdata_o = 32'h0000_0000;
      end
    end
  end

  // FSM state, lock owner and round-robin priority.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_own   <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      if (w_push) begin
        r_prio <= ~w_sel;
      end
    end
  end

  // Owner FIFO storage, pointers and outstanding count.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        r_fifo[i] <= 1'b0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_perr <= 1'b0;
    end else if (w_spurious || w_drop) begin
      r_perr <= 1'b1;
    end
  end

endmodule
